// File: rtl/jtframe_mcu_mailbox.sv
// Two-way byte mailbox between a main CPU and an 8751-class MCU external-data bus.
// Define JTFRAME_MCU_MAILBOX_IRQ_EN to drive cpu_irqn from the MCU-to-main full flag.
module jtframe_mcu_mailbox #(
  parameter logic [7:0] XPAGE = 8'hFF,
  parameter int         DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          cpu_addr,
  input  logic [DW-1:0] cpu_dout,
  input  logic          cpu_we,
  input  logic          cpu_rd,
  output logic [DW-1:0] cpu_din,
  output logic          cpu_irqn,
  input  logic [15:0]   x_addr,
  input  logic [DW-1:0] x_dout,
  input  logic          x_wr,
  output logic [DW-1:0] x_din,
  output logic          int0n
);

  logic [DW-1:0] m2s_data, s2m_data;
  logic          m2s_full, s2m_full, ovr, xwr_l;
  logic          page_hit, mcu_wr, mcu_wr_data, mcu_ack;
  logic          cpu_wr_data, cpu_rd_data, cpu_rd_stat;
  logic          m2s_full_nx, s2m_full_nx, ovr_nx;
  logic          unused;

  assign unused = &{1'b0, x_addr[7:2]};

  assign page_hit    = x_addr[15:8] == XPAGE;
  // One commit per x_wr pulse: rising edge as seen through cen sampling
  assign mcu_wr      = page_hit & cen & x_wr & ~xwr_l;
  assign mcu_wr_data = mcu_wr & (x_addr[1:0] == 2'd0);
  assign mcu_ack     = mcu_wr & (x_addr[1:0] == 2'd1);

  assign cpu_wr_data = cpu_we & ~cpu_addr;
  assign cpu_rd_data = cpu_rd & ~cpu_addr;
  assign cpu_rd_stat = cpu_rd & cpu_addr;

  // Setting a flag always takes priority over clearing it on the same edge
  assign m2s_full_nx = cpu_wr_data | (m2s_full & ~mcu_ack);
  assign s2m_full_nx = mcu_wr_data | (s2m_full & ~cpu_rd_data);
  assign ovr_nx      = (cpu_wr_data & m2s_full) | (mcu_wr_data & s2m_full)
                     | (ovr & ~cpu_rd_stat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2s_data <= '0;
      s2m_data <= '0;
      m2s_full <= 1'b0;
      s2m_full <= 1'b0;
      ovr      <= 1'b0;
      xwr_l    <= 1'b1;
      int0n    <= 1'b1;
    end else begin
      if (cen) xwr_l <= x_wr;
      if (cpu_wr_data) m2s_data <= cpu_dout;
      if (mcu_wr_data) s2m_data <= x_dout;
      m2s_full <= m2s_full_nx;
      s2m_full <= s2m_full_nx;
      ovr      <= ovr_nx;
      int0n    <= ~m2s_full_nx;
    end
  end

`ifdef JTFRAME_MCU_MAILBOX_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cpu_irqn <= 1'b1;
    else        cpu_irqn <= ~s2m_full_nx;
  end
`else
  assign cpu_irqn = 1'b1;
`endif

  always_comb begin
    cpu_din = s2m_data;
    if (cpu_addr) cpu_din = {{(DW-3){1'b0}}, ovr, s2m_full, m2s_full};
  end

  always_comb begin
    x_din = {DW{1'b1}};
    if (page_hit) begin
      case (x_addr[1:0])
        2'd0:    x_din = m2s_data;
        2'd1:    x_din = {{(DW-2){1'b0}}, s2m_full, m2s_full};
        default: x_din = {DW{1'b1}};
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_mcu_mailbox.sv
// Scoreboard bench for jtframe_mcu_mailbox: directed scenarios then random traffic
// against a slot-level model of the two mailboxes.
module tb_jtframe_mcu_mailbox;

  logic        clk = 1'b0;
  logic        rst_n, cen, cpu_addr, cpu_we, cpu_rd, x_wr;
  logic [7:0]  cpu_dout, x_dout;
  logic [15:0] x_addr;
  wire  [7:0]  cpu_din, x_din;
  wire         cpu_irqn, int0n;

  jtframe_mcu_mailbox dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we), .cpu_rd(cpu_rd),
    .cpu_din(cpu_din), .cpu_irqn(cpu_irqn),
    .x_addr(x_addr), .x_dout(x_dout), .x_wr(x_wr), .x_din(x_din), .int0n(int0n)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // cen pattern: high every cen_div-th clock
  int cen_div = 1;
  int cen_cnt = 0;
  initial begin
    cen = 1'b1;
    forever begin
      @(posedge clk); #1;
      cen_cnt++;
      cen = (cen_cnt % cen_div) == 0;
    end
  end

  // Reference model: each direction is a one-byte slot with a full flag
  logic [7:0] md, sd;
  logic       mf, sf, ov;

  task automatic m_reset();
    md = 8'h00; sd = 8'h00; mf = 1'b0; sf = 1'b0; ov = 1'b0;
  endtask

  task automatic m_edge(input bit cw, input bit crd, input bit crs,
                        input bit xw, input bit xa,
                        input logic [7:0] cd, input logic [7:0] xd);
    bit new_ov;
    new_ov = ov;
    if (crs) new_ov = 1'b0;
    if ((cw && mf) || (xw && sf)) new_ov = 1'b1;
    ov = new_ov;
    if (xa) mf = 1'b0;
    if (cw) begin mf = 1'b1; md = cd; end
    if (crd) sf = 1'b0;
    if (xw) begin sf = 1'b1; sd = xd; end
  endtask

  function automatic logic [7:0] status();
    return {5'b0, ov, sf, mf};
  endfunction

  function automatic logic [7:0] x_exp(input logic [15:0] a);
    if (a[15:8] != 8'hFF) return 8'hFF;
    case (a[1:0])
      2'd0:    return md;
      2'd1:    return {6'b0, sf, mf};
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic irq_exp();
`ifdef JTFRAME_MCU_MAILBOX_IRQ_EN
    return ~sf;
`else
    return 1'b1;
`endif
  endfunction

  // Scoreboard: 0 cpu_din, 1 x_din, 2 int0n, 3 cpu_irqn
  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      name;
  } sb_t;
  sb_t sb[$];
  sb_t mon_e;
  logic [7:0] mon_got;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      case (mon_e.kind)
        0:       mon_got = cpu_din;
        1:       mon_got = x_din;
        2:       mon_got = {7'b0, int0n};
        default: mon_got = {7'b0, cpu_irqn};
      endcase
      total++;
      if (mon_got !== mon_e.exp) begin
        bad++;
        $display("FAIL %s: got %h expected %h", mon_e.name, mon_got, mon_e.exp);
      end
    end
  end

  task automatic push(input int kind, input logic [7:0] exp, input string name);
    sb_t e;
    e.kind = kind; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timeout, got no response expected completion", name);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 8 && sb.size() > 0; i++) @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      timeout(name);
      sb.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_x(input logic [15:0] a, input string name);
    x_addr = a;
    push(1, x_exp(a), name);
    drain(name);
  endtask

  task automatic check_status(input string name);
    cpu_addr = 1'b1;
    push(0, status(), name);
    drain(name);
  endtask

  task automatic check_pins(input string name);
    push(2, {7'b0, ~mf}, {name, "_int0n"});
    drain(name);
    push(3, {7'b0, irq_exp()}, {name, "_irqn"});
    drain(name);
  endtask

  task automatic cpu_write(input logic a, input logic [7:0] d);
    cpu_addr = a; cpu_dout = d; cpu_we = 1'b1;
    @(posedge clk); #1;
    cpu_we = 1'b0;
    m_edge(!a, 0, 0, 0, 0, d, 8'h00);
  endtask

  task automatic cpu_read(input logic a, input string name);
    cpu_addr = a; cpu_rd = 1'b1;
    push(0, a ? status() : sd, name);
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    m_edge(0, !a, a, 0, 0, 8'h00, 8'h00);
    drain(name);
  endtask

  task automatic mcu_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    int n, guard;
    x_addr = a; x_dout = d; x_wr = 1'b1;
    n = 0; guard = 0;
    while (n < hold && guard < 200) begin
      @(posedge clk);
      if (cen) n++;
      guard++;
    end
    #1 x_wr = 1'b0;
    n = 0;
    while (n < 1 && guard < 400) begin
      @(posedge clk);
      if (cen) n++;
      guard++;
    end
    #1;
    if (guard >= 200) timeout("mcu_write_cen");
    if (a[15:8] == 8'hFF)
      m_edge(0, 0, 0, a[1:0] == 2'd0, a[1:0] == 2'd1, 8'h00, d);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    logic [7:0]  rd;
    rst_n = 1'b0; cpu_addr = 1'b0; cpu_dout = 8'h00; cpu_we = 1'b0; cpu_rd = 1'b0;
    x_addr = 16'h0000; x_dout = 8'h00; x_wr = 1'b0;
    m_reset();
    idle(3);
    rst_n = 1'b1;
    idle(2);

    check_pins("reset");
    check_status("reset_status");
    check_x(16'hFF01, "reset_xstat");

    cpu_write(1'b0, 8'h5A);
    idle(1);
    check_pins("m2s_set");
    check_x(16'hFF00, "m2s_data");
    check_x(16'hFF01, "m2s_xstat");
    mcu_write(16'hFF01, 8'h00, 1);
    idle(1);
    check_pins("m2s_ack");
    check_status("after_ack");

    cen_div = 4;
    mcu_write(16'hFF00, 8'hC3, 5);
    cen_div = 1;
    idle(1);
    cpu_addr = 1'b0;
    push(0, sd, "s2m_peek");
    drain("s2m_peek");
    check_status("s2m_status");
    check_pins("s2m_set");
    cpu_read(1'b0, "s2m_read");
    idle(1);
    check_status("s2m_cleared");
    check_pins("s2m_clr");

    cpu_write(1'b0, 8'h11);
    cpu_write(1'b0, 8'h22);
    idle(1);
    check_x(16'hFF00, "ovr_data");
    cpu_read(1'b1, "ovr_status");
    cpu_read(1'b1, "ovr_cleared");
    mcu_write(16'hFF01, 8'h00, 1);

    // Main write and MCU ack on the same edge
    x_addr = 16'hFF01; x_dout = 8'h00; x_wr = 1'b1;
    cpu_addr = 1'b0; cpu_dout = 8'h77; cpu_we = 1'b1;
    @(posedge clk); #1;
    cpu_we = 1'b0; x_wr = 1'b0;
    idle(1);
    m_edge(1, 0, 0, 0, 1, 8'h77, 8'h00);
    check_status("coll_ack_status");
    check_x(16'hFF00, "coll_ack_data");
    mcu_write(16'hFF01, 8'h00, 1);

    // MCU data write and main data read on the same edge
    mcu_write(16'hFF00, 8'h3C, 1);
    cpu_addr = 1'b0; cpu_rd = 1'b1;
    push(0, sd, "coll_rd_old");
    x_addr = 16'hFF00; x_dout = 8'h99; x_wr = 1'b1;
    @(posedge clk); #1;
    cpu_rd = 1'b0; x_wr = 1'b0;
    idle(1);
    m_edge(0, 1, 0, 1, 0, 8'h00, 8'h99);
    drain("coll_rd_old");
    check_status("coll_rd_status");
    cpu_read(1'b0, "coll_rd_new");
    cpu_read(1'b1, "coll_rd_ovr");

    mcu_write(16'hFE00, 8'hAB, 1);
    mcu_write(16'hFF02, 8'hAB, 1);
    idle(1);
    check_status("decode_nochange");
    check_x(16'hFE00, "decode_page");
    check_x(16'hFF02, "decode_addr2");
    check_x(16'hFF03, "decode_addr3");

    // x_wr held high across reset must not commit
    cpu_write(1'b0, 8'h42);
    x_addr = 16'hFF00; x_dout = 8'hEE; x_wr = 1'b1;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    m_reset();
    idle(4);
    check_status("rst_pulse_nocommit");
    x_wr = 1'b0;
    idle(2);
    check_status("rst_pulse_after");
    check_pins("rst_pins");

    for (int it = 0; it < 300; it++) begin
      rd = 8'($urandom);
      case ($urandom_range(0, 7))
        0: cpu_write(1'b0, rd);
        1: cpu_read(1'b0, "rnd_rd_data");
        2: cpu_read(1'b1, "rnd_rd_status");
        3: begin
          cen_div = $urandom_range(1, 3);
          mcu_write(16'hFF00, rd, $urandom_range(1, 3));
          cen_div = 1;
        end
        4: begin
          cen_div = $urandom_range(1, 3);
          mcu_write(16'hFF01, rd, $urandom_range(1, 3));
          cen_div = 1;
        end
        5: begin
          ra = 16'($urandom);
          if ($urandom_range(0, 1) == 1) ra[15:8] = 8'hFF;
          mcu_write(ra, rd, 1);
        end
        6: begin
          ra = {8'hFF, 6'($urandom), 2'($urandom)};
          if ($urandom_range(0, 3) == 0) ra[15:8] = 8'($urandom);
          check_x(ra, "rnd_xdin");
        end
        default: cpu_write(1'b1, rd);
      endcase
      idle(1);
      if (it % 4 == 0) check_pins("rnd");
      if (it % 3 == 0) check_status("rnd_status");
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
